// File: rtl/video_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : video_timing
// Description : Raster timing generator (blank-first lines, visible-first
//               frames). Optional macro VIDEO_SYNC_DELAY_EN delays
//               hsync/vsync/de by SYNC_DELAY cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int H_W        = 10,
    parameter int V_W        = 10,
    parameter int SYNC_DELAY = 2
) (
    input  logic           clk,
    input  logic           reset,
    output logic [H_W-1:0] h_count_o,
    output logic [V_W-1:0] v_count_o,
    output logic           v_visible_o,
    output logic           end_of_line_o,
    output logic           end_of_frame_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           de_o
);

    localparam int OFF_W   = H_FRONT + H_SYNC + H_BACK;
    localparam int TOTAL_W = OFF_W + H_VISIBLE;
    localparam int TOTAL_H = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [H_W-1:0] H_LAST = H_W'(TOTAL_W - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(TOTAL_H - 1);

    // Window bounds carry one extra bit so an end bound equal to 2**W still fits.
    localparam logic [H_W:0] HS_START = (H_W+1)'(H_FRONT);
    localparam logic [H_W:0] HS_END   = (H_W+1)'(H_FRONT + H_SYNC);
    localparam logic [H_W:0] DE_START = (H_W+1)'(OFF_W);
    localparam logic [V_W:0] VIS_END  = (V_W+1)'(V_VISIBLE);
    localparam logic [V_W:0] VS_START = (V_W+1)'(V_VISIBLE + V_FRONT);
    localparam logic [V_W:0] VS_END   = (V_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

    if (longint'(TOTAL_W) > (longint'(1) << H_W)) begin : g_h_width_err
        $error("video_timing: TOTAL_W does not fit in H_W bits");
    end
    if (longint'(TOTAL_H) > (longint'(1) << V_W)) begin : g_v_width_err
        $error("video_timing: TOTAL_H does not fit in V_W bits");
    end
    if (SYNC_DELAY < 1 || SYNC_DELAY > 7) begin : g_delay_range_err
        $error("video_timing: SYNC_DELAY must be 1..7");
    end

    logic [H_W-1:0] h_count_q, h_count_d;
    logic [V_W-1:0] v_count_q, v_count_d;
    logic [H_W:0]   h_ext_d;
    logic [V_W:0]   v_ext_d;
    logic           v_visible_q, v_visible_d;
    logic           eol_q, eol_d;
    logic           eof_q, eof_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           de_q, de_d;

    // Flags are derived from the next counter values so they register
    // alongside the counters and always describe the same cycle.
    always_comb begin
        h_count_d = h_count_q + H_W'(1);
        v_count_d = v_count_q;
        if (h_count_q == H_LAST) begin
            h_count_d = '0;
            v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + V_W'(1);
        end
        h_ext_d     = {1'b0, h_count_d};
        v_ext_d     = {1'b0, v_count_d};
        v_visible_d = (v_ext_d < VIS_END);
        eol_d       = (h_count_d == H_LAST);
        eof_d       = eol_d && (v_count_d == V_LAST);
        hsync_d     = ((h_ext_d >= HS_START) && (h_ext_d < HS_END)) ? H_SYNC_POL : !H_SYNC_POL;
        vsync_d     = ((v_ext_d >= VS_START) && (v_ext_d < VS_END)) ? V_SYNC_POL : !V_SYNC_POL;
        de_d        = v_visible_d && (h_ext_d >= DE_START);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_count_q   <= '0;
            v_count_q   <= '0;
            v_visible_q <= 1'b1;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            hsync_q     <= !H_SYNC_POL;
            vsync_q     <= !V_SYNC_POL;
            de_q        <= 1'b0;
        end else begin
            h_count_q   <= h_count_d;
            v_count_q   <= v_count_d;
            v_visible_q <= v_visible_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
        end
    end

    assign h_count_o      = h_count_q;
    assign v_count_o      = v_count_q;
    assign v_visible_o    = v_visible_q;
    assign end_of_line_o  = eol_q;
    assign end_of_frame_o = eof_q;

`ifdef VIDEO_SYNC_DELAY_EN
    // Each stage holds {hsync, vsync, de}; strobes and counters bypass it.
    logic [2:0] sync_pipe_q [SYNC_DELAY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_DELAY; i++) begin
                sync_pipe_q[i] <= {!H_SYNC_POL, !V_SYNC_POL, 1'b0};
            end
        end else begin
            sync_pipe_q[0] <= {hsync_q, vsync_q, de_q};
            for (int i = 1; i < SYNC_DELAY; i++) begin
                sync_pipe_q[i] <= sync_pipe_q[i-1];
            end
        end
    end

    assign hsync_o = sync_pipe_q[SYNC_DELAY-1][2];
    assign vsync_o = sync_pipe_q[SYNC_DELAY-1][1];
    assign de_o    = sync_pipe_q[SYNC_DELAY-1][0];
`else
    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign de_o    = de_q;
`endif

endmodule
`default_nettype wire
